// File: rtl/matrix_adder_host_pkg.sv
// Shared definitions for the matrix adder host: bus field widths, slave region
// codes, control register bit positions and the sequencer state encoding.
package matrix_adder_host_pkg;

    localparam int ADDR_W = 10;
    localparam int BUS_W  = 32;
    localparam int IDX_W  = 8;

    localparam logic [1:0] CTRL    = 2'b00;
    localparam logic [1:0] MAT_A   = 2'b01;
    localparam logic [1:0] MAT_B   = 2'b10;
    localparam logic [1:0] MAT_RES = 2'b11;

    localparam int START     = 0;
    localparam int DONE      = 1;
    localparam int RST_ENTRY = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_CLR_SET,
        ST_CLR_REL,
        ST_RUN_SET,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_RUN_CLR,
        ST_RES_RD,
        ST_RES_WAIT,
        ST_RES_OUT
    } state_e;

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [1:0] region,
                                                  input logic [IDX_W-1:0] idx);
        return {region, idx};
    endfunction

    function automatic logic [BUS_W-1:0] ctrl_bit(input int unsigned pos);
        return BUS_W'(1) << pos;
    endfunction

endpackage

// File: rtl/matrix_adder_host_if.sv
// Avalon-MM link between the host (master) and the matrix add accelerator (slave).
interface matrix_adder_host_if;
    import matrix_adder_host_pkg::*;

    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic              master_write;
    logic [BUS_W-1:0]  master_writedata;
    logic [3:0]        master_byteenable;
    logic [BUS_W-1:0]  master_readdata;
    logic              master_waitrequest;

    modport master (
        output master_address, master_read, master_write,
               master_writedata, master_byteenable,
        input  master_readdata, master_waitrequest
    );

    modport slave (
        input  master_address, master_read, master_write,
               master_writedata, master_byteenable,
        output master_readdata, master_waitrequest
    );

endinterface

// File: rtl/matrix_adder_host_avmm_read_latency_tracker.sv
// Strobes rvalid_o in the cycle readdata is valid, READ_LATENCY cycles after
// an accepted read; shared by the done-poll and result-readback phases.
module avmm_read_latency_tracker #(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic accept_i,
    output logic rvalid_o
);

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept_i) begin
            cnt_d = 2'(READ_LATENCY);
        end else if (cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rvalid_o = (cnt_q == 2'd1);

endmodule

// File: rtl/matrix_adder_host.sv
// Avalon-MM master that loads A and B into the matrix add accelerator, steps
// every entry through start/done, then streams the result matrix out.
module matrix_adder_host
    import matrix_adder_host_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 256,
    parameter int READ_LATENCY = 1,
    parameter int POLL_LIMIT   = 1023
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    matrix_adder_host_if.master   bus
);

    localparam int               PC_W      = $clog2(POLL_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [PC_W-1:0]  POLL_LAST = PC_W'(POLL_LIMIT - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PC_W-1:0]         pollcnt_q, pollcnt_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [ADDR_W-1:0]       addr;
    logic [BUS_W-1:0]        wdata;
    logic                    rd_req, wr_req;
    logic                    stall;
    logic                    rvalid;

    assign stall = bus.master_waitrequest;

    avmm_read_latency_tracker #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_lat (
        .clk      (clk),
        .reset    (reset),
        .accept_i (rd_req & ~stall),
        .rvalid_o (rvalid)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pollcnt_d   = pollcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        in_ready    = 1'b0;
        rd_req      = 1'b0;
        wr_req      = 1'b0;
        addr        = '0;
        wdata       = '0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    idx_d   = '0;
                    state_d = ST_LOAD_A;
                end
            end
            // The source sees the bus stall directly, so it holds its word for us.
            ST_LOAD_A, ST_LOAD_B: begin
                in_ready = ~stall;
                wr_req   = in_valid;
                addr     = mk_addr((state_q == ST_LOAD_A) ? MAT_A : MAT_B, idx_q);
                wdata    = in_data;
                if (in_valid && !stall) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_CLR_SET;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_CLR_SET: begin
                wr_req = 1'b1;
                addr   = mk_addr(CTRL, '0);
                wdata  = ctrl_bit(RST_ENTRY);
                if (!stall) state_d = ST_CLR_REL;
            end
            ST_CLR_REL: begin
                wr_req = 1'b1;
                addr   = mk_addr(CTRL, '0);
                if (!stall) begin
                    idx_d   = '0;
                    state_d = ST_RUN_SET;
                end
            end
            ST_RUN_SET: begin
                wr_req = 1'b1;
                addr   = mk_addr(CTRL, '0);
                wdata  = ctrl_bit(START);
                if (!stall) begin
                    pollcnt_d = '0;
                    state_d   = ST_POLL_RD;
                end
            end
            ST_POLL_RD: begin
                rd_req = 1'b1;
                addr   = mk_addr(CTRL, '0);
                if (!stall) state_d = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                if (rvalid) begin
                    if (bus.master_readdata[DONE]) begin
                        state_d = ST_RUN_CLR;
                    end else if (pollcnt_q == POLL_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        pollcnt_d = pollcnt_q + 1'b1;
                        state_d   = ST_POLL_RD;
                    end
                end
            end
            ST_RUN_CLR: begin
                wr_req = 1'b1;
                addr   = mk_addr(CTRL, '0);
                if (!stall) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_RES_RD;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RUN_SET;
                    end
                end
            end
            ST_RES_RD: begin
                rd_req = 1'b1;
                addr   = mk_addr(MAT_RES, idx_q);
                if (!stall) state_d = ST_RES_WAIT;
            end
            ST_RES_WAIT: begin
                if (rvalid) begin
                    out_data_d  = bus.master_readdata;
                    out_valid_d = 1'b1;
                    state_d     = ST_RES_OUT;
                end
            end
            ST_RES_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_RES_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pollcnt_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pollcnt_q   <= pollcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // done/err are registered, so they appear as the state lands back in IDLE.
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    assign bus.master_address    = addr;
    assign bus.master_read       = rd_req;
    assign bus.master_write      = wr_req;
    assign bus.master_writedata  = wdata;
    assign bus.master_byteenable = 4'hF;

endmodule

// File: tb/tb_matrix_adder_host.sv
// Directed bench for matrix_adder_host with a behavioural accelerator slave.
module tb_matrix_adder_host;

    localparam int NW = 4;
    localparam int RL = 2;
    localparam int PL = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        busy, done, err;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    matrix_adder_host_if bus ();

    matrix_adder_host #(
        .DATA_WIDTH   (32),
        .NUM_WORDS    (NW),
        .READ_LATENCY (RL),
        .POLL_LIMIT   (PL)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .go        (go),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Accelerator model: per-lane 8-bit adds, done appears on the second poll.
    logic [31:0] mem_a [NW];
    logic [31:0] mem_b [NW];
    logic [31:0] mem_r [NW];
    int          entry     = 0;
    bit          done_flag = 1'b0;
    int          pending   = 0;
    bit          never_done = 1'b0;
    logic [31:0] rd_p0 = 32'hDEAD_BEEF;
    logic [31:0] rd_p1 = 32'hDEAD_BEEF;
    bit          stall_en = 1'b0;

    assign bus.master_readdata = rd_p1;

    function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        rd_p1 <= rd_p0;
        rd_p0 <= 32'hDEAD_BEEF;
        if (bus.master_write && !bus.master_waitrequest) begin
            case (bus.master_address[9:8])
                2'b01: mem_a[bus.master_address[1:0]] <= bus.master_writedata;
                2'b10: mem_b[bus.master_address[1:0]] <= bus.master_writedata;
                2'b00: begin
                    if (bus.master_writedata[2]) begin
                        entry <= 0;
                    end else if (bus.master_writedata[0]) begin
                        mem_r[entry % NW] <= lane_add(mem_a[entry % NW], mem_b[entry % NW]);
                        pending   <= 1;
                        done_flag <= 1'b0;
                    end else if (done_flag) begin
                        done_flag <= 1'b0;
                        entry     <= entry + 1;
                    end
                end
                default: ;
            endcase
        end
        if (bus.master_read && !bus.master_waitrequest) begin
            if (bus.master_address[9:8] == 2'b11) begin
                rd_p0 <= mem_r[bus.master_address[1:0]];
            end else if (never_done) begin
                rd_p0 <= 32'h0;
            end else if (pending > 0) begin
                pending <= pending - 1;
                rd_p0   <= 32'h0;
            end else begin
                done_flag <= 1'b1;
                rd_p0     <= 32'h2;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        bus.master_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Bus/stream monitor, sampled mid-cycle.
    int          wr_a_n = 0, wr_b_n = 0, wr_ctrl_n = 0, rd_ctrl_n = 0, rd_res_n = 0;
    int          done_n = 0, err_n = 0, pulse_busy_n = 0, both_n = 0, unstable_n = 0;
    int          out_n = 0;
    logic [31:0] out_words [64];
    bit          stalled_q = 1'b0;
    logic [9:0]  s_addr;
    logic [31:0] s_wd;
    logic        s_rd, s_wr;
    bit          need_first = 1'b0;
    logic [9:0]  first_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled_q <= 1'b0;
        end else begin
            if (stalled_q && (bus.master_address != s_addr || bus.master_read != s_rd ||
                              bus.master_write != s_wr ||
                              (bus.master_write && bus.master_writedata != s_wd)))
                unstable_n <= unstable_n + 1;
            stalled_q <= (bus.master_read || bus.master_write) && bus.master_waitrequest;
            s_addr    <= bus.master_address;
            s_wd      <= bus.master_writedata;
            s_rd      <= bus.master_read;
            s_wr      <= bus.master_write;
            if (bus.master_read && bus.master_write) both_n <= both_n + 1;
            if (bus.master_write && !bus.master_waitrequest) begin
                case (bus.master_address[9:8])
                    2'b00:   wr_ctrl_n <= wr_ctrl_n + 1;
                    2'b01:   wr_a_n    <= wr_a_n + 1;
                    2'b10:   wr_b_n    <= wr_b_n + 1;
                    default: ;
                endcase
                if (need_first) begin
                    first_addr <= bus.master_address;
                    need_first <= 1'b0;
                end
            end
            if (bus.master_read && !bus.master_waitrequest) begin
                if (bus.master_address[9:8] == 2'b00) rd_ctrl_n <= rd_ctrl_n + 1;
                if (bus.master_address[9:8] == 2'b11) rd_res_n  <= rd_res_n + 1;
            end
            if (out_valid && out_ready) begin
                out_words[out_n % 64] <= out_data;
                out_n <= out_n + 1;
            end
            if (done) done_n <= done_n + 1;
            if (err)  err_n  <= err_n + 1;
            if ((done || err) && busy) pulse_busy_n <= pulse_busy_n + 1;
            if (go && !busy) need_first <= 1'b1;
        end
    end

    logic [31:0] va [NW];
    logic [31:0] vb [NW];
    logic [31:0] ve [NW];
    int b_wa, b_wb, b_wc, b_rc, b_rr, b_done, b_err, b_out;

    task automatic snap();
        b_wa = wr_a_n; b_wb = wr_b_n; b_wc = wr_ctrl_n; b_rc = rd_ctrl_n;
        b_rr = rd_res_n; b_done = done_n; b_err = err_n; b_out = out_n;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        int t;
        bit acc;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        acc = 1'b0;
        while (!acc && t < 500) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        if (!acc) check("src_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_run(input string tag, input bit gaps, input bit bp, input bit go_in_run);
        int t;
        out_ready = !bp;
        pulse_go();
        check({tag, "_busy_after_go"}, {31'd0, busy}, 32'd1);
        fork
            begin
                for (int i = 0; i < NW; i++) send_word(va[i], gaps);
                for (int i = 0; i < NW; i++) send_word(vb[i], gaps);
            end
            begin
                if (bp) begin
                    for (int i = 0; i < 5000 && !out_valid; i++) begin
                        @(posedge clk); #1;
                    end
                    repeat (5) begin
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
            end
            begin
                if (go_in_run) begin
                    for (int i = 0; i < 5000; i++) begin
                        @(negedge clk);
                        if (bus.master_write && bus.master_address == 10'h000 &&
                            bus.master_writedata == 32'h1) break;
                    end
                    go = 1'b1;
                    @(negedge clk);
                    go = 1'b0;
                end
            end
        join
        t = 0;
        while (done_n == b_done && err_n == b_err && t < 5000) begin
            @(posedge clk); #1;
            t++;
        end
        check({tag, "_end_timeout"}, {31'd0, (t >= 5000)}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_results(input string tag);
        check({tag, "_out_count"}, 32'(out_n - b_out), 32'(NW));
        for (int k = 0; k < NW; k++)
            check($sformatf("%s_out%0d", tag, k), out_words[(b_out + k) % 64], ve[k]);
        check({tag, "_done_pulses"}, 32'(done_n - b_done), 32'd1);
        check({tag, "_err_pulses"}, 32'(err_n - b_err), 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_wr_a"}, 32'(wr_a_n - b_wa), 32'(NW));
        check({tag, "_wr_b"}, 32'(wr_b_n - b_wb), 32'(NW));
        check({tag, "_wr_ctrl"}, 32'(wr_ctrl_n - b_wc), 32'(2 + 2 * NW));
        check({tag, "_polls"}, 32'(rd_ctrl_n - b_rc), 32'(2 * NW));
        check({tag, "_rd_res"}, 32'(rd_res_n - b_rr), 32'(NW));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        bus.master_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_read", {31'd0, bus.master_read}, 32'd0);
        check("rst_write", {31'd0, bus.master_write}, 32'd0);
        check("rst_addr", {22'd0, bus.master_address}, 32'd0);
        check("rst_wdata", bus.master_writedata, 32'd0);
        check("rst_byteen", {28'd0, bus.master_byteenable}, 32'hF);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic run, with a stray go while the entry loop is active.
        va = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        vb = '{32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010};
        ve = '{32'h11111111, 32'h12121212, 32'h13131313, 32'h14141414};
        snap();
        do_run("basic", 1'b0, 1'b0, 1'b1);
        check_results("basic");

        // Lane wrap under bus stalls, source gaps and sink backpressure.
        va = '{32'hFF807F01, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};
        vb = '{32'h01800101, 32'h00000000, 32'h01010101, 32'h11111111};
        ve = '{32'h00008002, 32'h00000000, 32'h00000000, 32'h23456789};
        stall_en = 1'b1;
        snap();
        do_run("bp", 1'b1, 1'b1, 1'b0);
        stall_en = 1'b0;
        check_results("bp");

        // Poll timeout.
        never_done = 1'b1;
        snap();
        do_run("tmo", 1'b0, 1'b0, 1'b0);
        never_done = 1'b0;
        check("tmo_err_pulses", 32'(err_n - b_err), 32'd1);
        check("tmo_done_pulses", 32'(done_n - b_done), 32'd0);
        check("tmo_polls", 32'(rd_ctrl_n - b_rc), 32'(PL));
        check("tmo_wr_ctrl", 32'(wr_ctrl_n - b_wc), 32'd3);
        check("tmo_rd_res", 32'(rd_res_n - b_rr), 32'd0);
        check("tmo_out_count", 32'(out_n - b_out), 32'd0);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        check("tmo_read", {31'd0, bus.master_read}, 32'd0);
        check("tmo_write", {31'd0, bus.master_write}, 32'd0);

        // Reset in the middle of loading B.
        va = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        vb = '{32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010};
        ve = '{32'h11111111, 32'h12121212, 32'h13131313, 32'h14141414};
        out_ready = 1'b1;
        snap();
        pulse_go();
        for (int i = 0; i < NW; i++) send_word(va[i], 1'b0);
        for (int i = 0; i < 2; i++) send_word(vb[i], 1'b0);
        in_valid = 1'b1;
        in_data  = vb[2];
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_write", {31'd0, bus.master_write}, 32'd0);
        check("mid_rst_read", {31'd0, bus.master_read}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("mid_rst_addr", {22'd0, bus.master_address}, 32'd0);
        check("mid_rst_wdata", bus.master_writedata, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_wr_b", 32'(wr_b_n - b_wb), 32'd2);

        snap();
        do_run("rerun", 1'b0, 1'b0, 1'b0);
        check("rerun_first_addr", {22'd0, first_addr}, 32'h100);
        check_results("rerun");

        check("bus_stable_under_stall", 32'(unstable_n), 32'd0);
        check("read_write_overlap", 32'(both_n), 32'd0);
        check("busy_during_pulse", 32'(pulse_busy_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_adder_host.md
Name: matrix_adder_host

Overview:
- Avalon-MM master that drives the 10-bit-address matrix add accelerator slave end to end.
- Loads matrix A then matrix B from an input stream.
- Sequences the per-entry start/done control handshake over all entries.
- Reads back the result matrix onto an output stream.
- Sits between a local data source/sink and the accelerator's slave port.

Parameters:
- DATA_WIDTH, 32, word width of streams and bus; only 32 supported.
- NUM_WORDS, 256, words per matrix; legal 1..256.
- READ_LATENCY, 1, fixed cycles from an accepted read to valid master_readdata; legal 1..3.
- POLL_LIMIT, 1023, maximum done-poll reads per entry before abort.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- go  in  1  start pulse; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  one-cycle pulse on poll timeout
- in_data  in  32  A/B words, A first, index order
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid & in_ready
- out_data  out  32  result word
- out_valid  out  1  out_data valid; held until accepted
- out_ready  in  1  sink accepts when out_valid & out_ready
- master_address  out  10  {region[1:0], index[7:0]}; region 00 control, 01 A, 10 B, 11 result
- master_read  out  1  read request
- master_write  out  1  write request
- master_writedata  out  32  write data
- master_byteenable  out  4  constant 4'hF
- master_readdata  in  32  read data, READ_LATENCY after accept
- master_waitrequest  in  1  stalls the current command

Behaviour:
- Reset values: all outputs 0 except master_byteenable = F. State = IDLE; all counters = 0.
- Bus rule: a command (read or write) holds address, data and strobe stable while master_waitrequest = 1. It completes on the first cycle with waitrequest = 0. Read and write are never asserted together. At most one transaction is outstanding.
- IDLE: on go = 1, clear idx and go to LOAD_A. go is ignored in every other state.
- LOAD_A:
  - in_ready = ~master_waitrequest.
  - master_write = in_valid.
  - Address = {01, idx}; writedata = in_data.
  - Each completed write increments idx.
  - After write NUM_WORDS-1: idx <= 0, go to LOAD_B.
  - in_valid gaps insert idle cycles with no bus activity.
- LOAD_B: same as LOAD_A with region 10. Exits to CLR_SET.
- CLR_SET: write control (address 0) = 32'h4 (reset entry counter). Then go to CLR_REL.
- CLR_REL: write control = 0. Then idx <= 0, go to RUN_SET.
- RUN_SET: write control = 1. Then pollcnt <= 0, go to POLL_RD.
- POLL_RD: read address 0. On accept, load latency counter = READ_LATENCY, go to POLL_WAIT.
- POLL_WAIT: count down; sample master_readdata when the counter hits 1.
  - Bit 1 = 1: go to RUN_CLR.
  - Bit 1 = 0 and pollcnt = POLL_LIMIT-1: pulse err, deassert all strobes, go to IDLE.
  - Otherwise: pollcnt++, go back to POLL_RD.
- RUN_CLR: write control = 0.
  - If idx = NUM_WORDS-1: idx <= 0, go to RES_RD.
  - Else: idx++, go to RUN_SET.
- RES_RD: read {11, idx}. Go to RES_WAIT.
- RES_WAIT: wait READ_LATENCY; capture readdata into out_data; assert out_valid; go to RES_OUT.
- RES_OUT:
  - Hold out_data and out_valid until out_ready.
  - On acceptance with idx = NUM_WORDS-1: pulse done, go to IDLE.
  - Otherwise: idx++, go to RES_RD.
- Counters: idx is 8 bits. NUM_WORDS = 256 terminates on idx = 255; idx never wraps mid-phase. pollcnt is ceil(log2(POLL_LIMIT+1)) bits.
- Reset asserted mid-operation: immediate return to reset values. Any partially issued bus command is dropped. The slave contents are not restored.
- done and err never assert in the same cycle.
- busy drops in the same cycle that done or err pulses.

Decomposition:
- Shared package holds:
  - region codes CTRL = 2'b00, MAT_A = 2'b01, MAT_B = 2'b10, MAT_RES = 2'b11;
  - control bits START = 0, DONE = 1, RST_ENTRY = 2;
  - the state enum.
- One sub-module, avmm_read_latency_tracker: given accept and READ_LATENCY, produces a data-valid strobe. It is reused by the poll and result phases.

Test Plan:
- Basic: NUM_WORDS = 4, A = {01010101, 02020202, 03030303, 04040404}, B all 10101010, no stalls, out_ready = 1 -> out = {11111111, 12121212, 13131313, 14141414}; done pulses once; busy = 0 afterwards.
- Byte wrap: A word FF80_7F01 + B word 0180_0101 -> result 0000_8002 (no carry between bytes).
- Backpressure: random master_waitrequest, in_valid gaps, and out_ready low for 5 cycles -> same results, no duplicated or lost words; address/data stable while stalled (assertion).
- Poll timeout: slave model never sets done, POLL_LIMIT = 8 -> exactly 8 poll reads, err pulses, done never pulses, state IDLE.
- Reset mid-LOAD_B: assert reset after 2 B writes -> all outputs 0 within same cycle. A fresh go then reloads from index 0 of A.
- go while busy: pulse go during RUN_SET -> ignored; transaction count unchanged (NUM_WORDS·2 loads + 2 clear writes + NUM_WORDS·2 run writes + polls + NUM_WORDS result reads).
